bsc_lite: RTL and testbench

BSC_LITE -- requirements
Module: bsc_lite

---
 rtl/bsc_lite.sv | 106 ++++++++++
 tb/tb_bsc_lite.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bsc_lite.sv
// bsc_lite: bus state controller bridging a 32-bit DBUS initiator onto a 16-bit external bus
module bsc_lite (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [27:0] DBUS_A,
  input  logic [31:0] DBUS_DI,
  output logic [31:0] DBUS_DO,
  input  logic [3:0]  DBUS_BA,
  input  logic        DBUS_WE,
  input  logic        DBUS_REQ,
  input  logic        DBUS_LOCK,
  output logic        DBUS_WAIT,
  output logic        BSC_ACK,
  input  logic [15:0] WAIT_CFG,
  output logic [21:0] EA,
  input  logic [15:0] ED_I,
  output logic [15:0] ED_O,
  output logic        ED_OE,
  output logic [7:0]  CS_N,
  output logic        RD_N,
  output logic        WRH_N,
  output logic        WRL_N,
  input  logic        WAIT_N
);
  typedef enum logic [2:0] {IDLE, TI, T1, T2, T2B} state_t;
  state_t state, state_nx;
  logic [2:0]  area_q;
  logic [21:0] addr_q;
  logic [3:0]  ba_q;
  logic [1:0]  cnt;
  logic [15:0] rd_tmp, hi_q;
  logic        we_q, half, wait_s, serviced, long_acc, byte_acc, ea1;
  logic        done_half, last, active, drive, unused;
  assign unused    = ^{DBUS_A[27], DBUS_A[23:22]};
  assign serviced  = DBUS_REQ && DBUS_A[26:24] != 3'd5 && DBUS_A[26:24] != 3'd7;
  assign long_acc  = ba_q == 4'hF;
  assign byte_acc  = $onehot(ba_q);
  assign ea1       = long_acc ? half : addr_q[1];
  assign done_half = state == T2 && cnt == 2'd0 && wait_s;
  assign last      = done_half && (!long_acc || half);
  assign active    = state inside {T1, T2, T2B};
  assign drive     = we_q && (state == T1 || state == T2);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else if (CE_R) state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = serviced ? T1 : IDLE;
      TI:      state_nx = IDLE;
      T1:      state_nx = T2;
      T2:      state_nx = !done_half ? T2 : !last ? T2B : DBUS_LOCK ? IDLE : TI;
      T2B:     state_nx = T1;
      default: state_nx = IDLE;
    endcase
  end
  // wait is held off during reset even while a request is pending
  assign DBUS_WAIT = RST_N && (active ? !last : (state == IDLE || state == TI) && serviced);
  assign BSC_ACK   = active;
  assign CS_N      = active ? ~(8'd1 << area_q) : 8'hFF;
  assign EA        = active ? {addr_q[21:2], ea1, byte_acc & addr_q[0]} : 22'd0;
  assign ED_OE     = drive;
  assign ED_O      = drive ? (ea1 ? DBUS_DI[15:0] : DBUS_DI[31:16]) : 16'd0;
  assign RD_N      = !(state == T2 && !we_q);
  assign WRH_N     = !(state == T2 && we_q && (ba_q[3] || ba_q[1]));
  assign WRL_N     = !(state == T2 && we_q && (ba_q[2] || ba_q[0]));
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      area_q  <= 3'd0;
      addr_q  <= 22'd0;
      ba_q    <= 4'd0;
      we_q    <= 1'b0;
      half    <= 1'b0;
      cnt     <= 2'd0;
      wait_s  <= 1'b1;
      rd_tmp  <= 16'd0;
      hi_q    <= 16'd0;
      DBUS_DO <= 32'd0;
    end else begin
      if (CE_F) begin
        wait_s <= WAIT_N;
        if (state == T2 && !we_q) rd_tmp <= ED_I;
      end
      if (CE_R) begin
        if (state == IDLE && serviced) begin
          area_q <= DBUS_A[26:24];
          addr_q <= DBUS_A[21:0];
          ba_q   <= DBUS_BA;
          we_q   <= DBUS_WE;
          half   <= 1'b0;
        end
        if (state == T1) cnt <= WAIT_CFG[{area_q, 1'b0} +: 2];
        if (state == T2 && cnt != 2'd0) cnt <= cnt - 2'd1;
        if (done_half && !last) begin
          half <= 1'b1;
          hi_q <= rd_tmp;
        end
        if (last) begin
          half <= 1'b0;
          if (!we_q) DBUS_DO <= long_acc ? {hi_q, rd_tmp} : {rd_tmp, rd_tmp};
        end
      end
    end
endmodule

// File: tb/tb_bsc_lite.sv
// tb_bsc_lite: directed scenario checks for bsc_lite
module tb_bsc_lite;
  logic        CLK = 0, RST_N = 1, CE_R = 0, CE_F = 0;
  logic [27:0] DBUS_A = 0;
  logic [31:0] DBUS_DI = 0, DBUS_DO;
  logic [3:0]  DBUS_BA = 0;
  logic        DBUS_WE = 0, DBUS_REQ = 0, DBUS_LOCK = 0, DBUS_WAIT, BSC_ACK;
  logic [15:0] WAIT_CFG = 0, ED_I = 0, ED_O;
  logic [21:0] EA;
  logic        ED_OE, RD_N, WRH_N, WRL_N, WAIT_N = 1;
  logic [7:0]  CS_N;
  int checks = 0, errors = 0;
  int n_pre, n_ack, n_wait0, n_rd, n_wrh, n_wrl, n_cs, wl = 0;
  logic [15:0] ed_a, ed_b, rd_hi = 0, rd_lo = 0;
  logic [7:0]  cs_v;
  logic [21:0] ea_first, ea_last;
  bit done, seen, seen_oe;

  bsc_lite dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .DBUS_A(DBUS_A), .DBUS_DI(DBUS_DI), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA),
    .DBUS_WE(DBUS_WE), .DBUS_REQ(DBUS_REQ), .DBUS_LOCK(DBUS_LOCK), .DBUS_WAIT(DBUS_WAIT),
    .BSC_ACK(BSC_ACK), .WAIT_CFG(WAIT_CFG), .EA(EA), .ED_I(ED_I), .ED_O(ED_O),
    .ED_OE(ED_OE), .CS_N(CS_N), .RD_N(RD_N), .WRH_N(WRH_N), .WRL_N(WRL_N), .WAIT_N(WAIT_N)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic ftick();
    CE_F = 1; @(posedge CLK); #1; CE_F = 0;
  endtask

  task automatic rtick();
    CE_R = 1; @(posedge CLK); #1; CE_R = 0;
  endtask

  task automatic req(input logic [27:0] a, input logic [3:0] ba, input logic we, input logic [31:0] di);
    DBUS_A = a; DBUS_BA = ba; DBUS_WE = we; DBUS_DI = di; DBUS_REQ = 1;
  endtask

  // Runs ticks until the first non-ACK tick after the access; observation is after CE_F, before CE_R.
  task automatic do_access(input int bound, input bit perturb);
    n_pre = 0; n_ack = 0; n_wait0 = 0; n_rd = 0; n_wrh = 0; n_wrl = 0; n_cs = 0;
    done = 0; seen = 0; seen_oe = 0; cs_v = 8'hFF; ed_a = 0; ed_b = 0; ea_first = 0; ea_last = 0;
    for (int i = 0; i < bound; i++) begin
      if (!RD_N && wl > 0) begin WAIT_N = 0; wl--; end else WAIT_N = 1;
      ED_I = EA[1] ? rd_lo : rd_hi;
      ftick();
      if (BSC_ACK) begin
        if (!seen) ea_first = EA;
        ea_last = EA; seen = 1; n_ack++;
        if (!DBUS_WAIT) n_wait0++;
      end else if (seen) begin
        done = 1;
        break;
      end else n_pre++;
      if (!RD_N) n_rd++;
      if (!WRH_N) n_wrh++;
      if (!WRL_N) n_wrl++;
      if (CS_N != 8'hFF) begin n_cs++; cs_v = CS_N; end
      if (ED_OE) begin
        if (!seen_oe) ed_a = ED_O;
        ed_b = ED_O; seen_oe = 1;
      end
      if (perturb && BSC_ACK) begin
        DBUS_REQ = 0; DBUS_A = 28'h5FFFFFF; DBUS_WE = 1; DBUS_BA = 4'b0001;
      end
      rtick();
    end
    WAIT_N = 1;
    checks++; if (!done) begin errors++; $display("FAIL access_timeout done=%0d exp 1", done); end
  endtask

  task automatic test_reset();
    #2 RST_N = 0; #2;
    checks++; if (DBUS_DO !== 32'd0) begin errors++; $display("FAIL rst_do got %h exp 0", DBUS_DO); end
    checks++; if (BSC_ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", BSC_ACK); end
    checks++; if (CS_N !== 8'hFF) begin errors++; $display("FAIL rst_cs got %h exp ff", CS_N); end
    checks++; if ({RD_N, WRH_N, WRL_N} !== 3'b111) begin errors++; $display("FAIL rst_strobes got %b exp 111", {RD_N, WRH_N, WRL_N}); end
    checks++; if ({ED_OE, ED_O, EA} !== 39'd0) begin errors++; $display("FAIL rst_bus got oe=%b ed=%h ea=%h exp 0", ED_OE, ED_O, EA); end
    req(28'h0000100, 4'b1100, 0, 0); #1;
    checks++; if (DBUS_WAIT !== 1'b0) begin errors++; $display("FAIL rst_wait got %b exp 0", DBUS_WAIT); end
    DBUS_REQ = 0;
    @(posedge CLK); #3 RST_N = 1; #1;
  endtask

  task automatic test_read16();
    WAIT_CFG = 0; rd_hi = 16'h1234; rd_lo = 16'h1234; DBUS_LOCK = 0;
    req(28'h0000100, 4'b1100, 0, 0); #1;
    checks++; if (DBUS_WAIT !== 1'b1) begin errors++; $display("FAIL r16_idle_wait got %b exp 1", DBUS_WAIT); end
    do_access(20, 0); DBUS_REQ = 0;
    checks++; if (n_pre != 1) begin errors++; $display("FAIL r16_pre got %0d exp 1", n_pre); end
    checks++; if (n_ack != 2) begin errors++; $display("FAIL r16_ticks got %0d exp 2", n_ack); end
    checks++; if (n_wait0 != 1) begin errors++; $display("FAIL r16_wait0 got %0d exp 1", n_wait0); end
    checks++; if (n_rd != 1) begin errors++; $display("FAIL r16_rd got %0d exp 1", n_rd); end
    checks++; if (n_cs != 2 || cs_v !== 8'hFE) begin errors++; $display("FAIL r16_cs got n=%0d v=%h exp 2 fe", n_cs, cs_v); end
    checks++; if (DBUS_DO !== 32'h12341234) begin errors++; $display("FAIL r16_do got %h exp 12341234", DBUS_DO); end
    checks++; if (ea_first !== 22'h000100) begin errors++; $display("FAIL r16_ea got %h exp 000100", ea_first); end
  endtask

  task automatic test_write32();
    WAIT_CFG = 16'h0020;
    req(28'h2000010, 4'hF, 1, 32'hAABBCCDD);
    do_access(40, 0); DBUS_REQ = 0;
    checks++; if (n_ack != 9) begin errors++; $display("FAIL w32_ticks got %0d exp 9", n_ack); end
    checks++; if (n_wait0 != 1) begin errors++; $display("FAIL w32_wait0 got %0d exp 1", n_wait0); end
    checks++; if (n_wrh != 6 || n_wrl != 6 || n_rd != 0) begin errors++; $display("FAIL w32_strobes got h=%0d l=%0d r=%0d exp 6 6 0", n_wrh, n_wrl, n_rd); end
    checks++; if (ed_a !== 16'hAABB || ed_b !== 16'hCCDD) begin errors++; $display("FAIL w32_data got %h %h exp aabb ccdd", ed_a, ed_b); end
    checks++; if (n_cs != 9 || cs_v !== 8'hFB) begin errors++; $display("FAIL w32_cs got n=%0d v=%h exp 9 fb", n_cs, cs_v); end
    checks++; if (ea_first !== 22'h000010 || ea_last !== 22'h000012) begin errors++; $display("FAIL w32_ea got %h %h exp 000010 000012", ea_first, ea_last); end
    checks++; if (DBUS_DO !== 32'h12341234) begin errors++; $display("FAIL w32_do_hold got %h exp 12341234", DBUS_DO); end
  endtask

  task automatic test_byte_write();
    WAIT_CFG = 0;
    req(28'h0000003, 4'b0001, 1, 32'h11223344);
    do_access(20, 0); DBUS_REQ = 0;
    checks++; if (n_wrl != 1 || n_wrh != 0) begin errors++; $display("FAIL bw_strobes got l=%0d h=%0d exp 1 0", n_wrl, n_wrh); end
    checks++; if (ed_a !== 16'h3344) begin errors++; $display("FAIL bw_data got %h exp 3344", ed_a); end
    checks++; if (ea_first !== 22'h000003 || n_ack != 2) begin errors++; $display("FAIL bw_ea got %h n=%0d exp 000003 2", ea_first, n_ack); end
  endtask

  task automatic test_wait_n();
    WAIT_CFG = 0; rd_hi = 16'h0F0F; rd_lo = 16'h0F0F; wl = 4;
    req(28'h1000200, 4'b0011, 0, 0);
    do_access(40, 0); DBUS_REQ = 0;
    checks++; if (n_ack != 6 || n_rd != 5) begin errors++; $display("FAIL wn_ticks got ack=%0d rd=%0d exp 6 5", n_ack, n_rd); end
    checks++; if (n_wait0 != 1) begin errors++; $display("FAIL wn_wait0 got %0d exp 1", n_wait0); end
    checks++; if (DBUS_DO !== 32'h0F0F0F0F || cs_v !== 8'hFD) begin errors++; $display("FAIL wn_do got %h cs=%h exp 0f0f0f0f fd", DBUS_DO, cs_v); end
  endtask

  task automatic test_read32();
    WAIT_CFG = 16'h0040; rd_hi = 16'h5566; rd_lo = 16'h7788;
    req(28'h3000020, 4'hF, 0, 0);
    do_access(40, 0); DBUS_REQ = 0;
    checks++; if (n_ack != 7 || n_rd != 4) begin errors++; $display("FAIL r32_ticks got ack=%0d rd=%0d exp 7 4", n_ack, n_rd); end
    checks++; if (DBUS_DO !== 32'h55667788) begin errors++; $display("FAIL r32_do got %h exp 55667788", DBUS_DO); end
  endtask

  task automatic test_back_to_back();
    WAIT_CFG = 0; DBUS_LOCK = 0; rd_hi = 16'hA5A5; rd_lo = 16'hA5A5;
    req(28'h0000100, 4'b1100, 0, 0); do_access(20, 0);
    rd_hi = 16'h5A5A; rd_lo = 16'h5A5A;
    req(28'h0000102, 4'b1100, 0, 0); do_access(20, 0);
    checks++; if (n_pre != 2) begin errors++; $display("FAIL b2b_nolock_gap got %0d exp 2", n_pre); end
    checks++; if (DBUS_DO !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_do got %h exp 5a5a5a5a", DBUS_DO); end
    DBUS_LOCK = 1;
    req(28'h0000100, 4'b1100, 0, 0); do_access(20, 0);
    req(28'h0000102, 4'b1100, 0, 0); do_access(20, 0);
    checks++; if (n_pre != 1) begin errors++; $display("FAIL b2b_lock_gap got %0d exp 1", n_pre); end
    DBUS_LOCK = 0; DBUS_REQ = 0;
  endtask

  task automatic test_capture();
    WAIT_CFG = 0; rd_hi = 16'h9ABC; rd_lo = 16'h9ABC;
    req(28'h0000104, 4'b1100, 0, 0);
    do_access(20, 1);
    checks++; if (DBUS_DO !== 32'h9ABC9ABC || n_ack != 2) begin errors++; $display("FAIL cap_do got %h n=%0d exp 9abc9abc 2", DBUS_DO, n_ack); end
    checks++; if (n_rd != 1 || n_wrh != 0 || ea_last !== 22'h000104) begin errors++; $display("FAIL cap_bus got rd=%0d wrh=%0d ea=%h exp 1 0 000104", n_rd, n_wrh, ea_last); end
  endtask

  task automatic test_unserviced();
    req(28'h5000000, 4'b1100, 0, 0); #1;
    checks++; if (DBUS_WAIT !== 1'b0 || CS_N !== 8'hFF) begin errors++; $display("FAIL a5_idle got wait=%b cs=%h exp 0 ff", DBUS_WAIT, CS_N); end
    for (int i = 0; i < 3; i++) begin ftick(); rtick(); end
    checks++; if (BSC_ACK !== 1'b0 || CS_N !== 8'hFF || DBUS_WAIT !== 1'b0) begin errors++; $display("FAIL a5_run got ack=%b cs=%h wait=%b exp 0 ff 0", BSC_ACK, CS_N, DBUS_WAIT); end
    DBUS_A = 28'h7000000; #1;
    checks++; if (DBUS_WAIT !== 1'b0) begin errors++; $display("FAIL a7_wait got %b exp 0", DBUS_WAIT); end
    DBUS_A = 28'h0000100; DBUS_REQ = 0; #1;
    checks++; if (DBUS_WAIT !== 1'b0) begin errors++; $display("FAIL noreq_wait got %b exp 0", DBUS_WAIT); end
  endtask

  task automatic test_reset_mid();
    WAIT_CFG = 16'h0003;
    req(28'h0000100, 4'b1100, 1, 32'hDEAD0000);
    for (int i = 0; i < 10 && WRH_N; i++) begin ftick(); rtick(); end
    checks++; if (WRH_N !== 1'b0 || ED_OE !== 1'b1) begin errors++; $display("FAIL rm_t2 got wrh=%b oe=%b exp 0 1", WRH_N, ED_OE); end
    RST_N = 0; #1;
    checks++; if (WRH_N !== 1'b1 || ED_OE !== 1'b0 || CS_N !== 8'hFF) begin errors++; $display("FAIL rm_outs got wrh=%b oe=%b cs=%h exp 1 0 ff", WRH_N, ED_OE, CS_N); end
    checks++; if (BSC_ACK !== 1'b0 || DBUS_WAIT !== 1'b0 || DBUS_DO !== 32'd0 || EA !== 22'd0) begin errors++; $display("FAIL rm_state got ack=%b wait=%b do=%h ea=%h exp 0 0 0 0", BSC_ACK, DBUS_WAIT, DBUS_DO, EA); end
    #3 RST_N = 1;
    WAIT_CFG = 0; rd_hi = 16'hC0DE; rd_lo = 16'hC0DE;
    req(28'h0000100, 4'b1100, 0, 0);
    do_access(20, 0); DBUS_REQ = 0;
    checks++; if (n_pre != 1 || n_ack != 2 || DBUS_DO !== 32'hC0DEC0DE) begin errors++; $display("FAIL rm_next got pre=%0d ack=%0d do=%h exp 1 2 c0dec0de", n_pre, n_ack, DBUS_DO); end
  endtask

  initial begin
    test_reset();
    test_read16();
    test_write32();
    test_byte_write();
    test_wait_n();
    test_read32();
    test_back_to_back();
    test_capture();
    test_unserviced();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
